i2c_arbiter: RTL and testbench

Shares one mod_I2C instance between two requesters (bus master port 0, sensor poller port 1), with round-robin arbitration.
Drives mod_I2C command/dataIn, times each transaction and returns dataOut to the granted requester as a one-cycle response strobe.
mod_I2C has no completion output, so every transaction gets a fixed cycle budget (XFER_CYCLES).

---
 rtl/i2c_arb_pkg.sv | 18 +
 rtl/i2c_arbiter_if.sv | 33 +++
 rtl/rr_arb2.sv | 28 ++
 rtl/i2c_arbiter.sv | 125 ++++++++++++
 tb/tb_i2c_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared command codes, FSM state encoding and command validation for the
// i2c_arbiter block.
package i2c_arb_pkg;

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_WRITE = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  function automatic logic is_valid_cmd(input logic [2:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester-facing bundle of the i2c_arbiter: two request ports, the shared
// response strobe and the busy flag.
interface i2c_arbiter_if #(
  parameter int DW = 32
);
  logic          req0_valid;
  logic          req0_ready;
  logic [2:0]    req0_cmd;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid;
  logic          req1_ready;
  logic [2:0]    req1_cmd;
  logic [DW-1:0] req1_wdata;
  logic          rsp_valid;
  logic          rsp_id;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          busy;

  modport master (
    output req0_valid, req0_cmd, req0_wdata,
    output req1_valid, req1_cmd, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_err, rsp_rdata, busy
  );

  modport slave (
    input  req0_valid, req0_cmd, req0_wdata,
    input  req1_valid, req1_cmd, req1_wdata,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_err, rsp_rdata, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, on contention the
// port that did not win last time is granted. Grant state moves on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_grant_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt[gi] = req[gi] & (~req[1-gi] | (last_grant_reg != 1'(gi)));
    end
  endgenerate

  // Resetting to port 1 makes port 0 the winner of the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= 1'b1;
    end else if (advance) begin
      last_grant_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one mod_I2C between two requesters; each transaction runs a fixed
// cycle budget because mod_I2C reports no completion.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int CMD_HOLD    = 4,
  parameter int XFER_CYCLES = 40,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  i2c_arbiter_if.slave  bus,
  output logic [DW-1:0] i2c_command,
  output logic [DW-1:0] i2c_dataIn,
  input  logic [DW-1:0] i2c_dataOut
);

  localparam int CW = $clog2(XFER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD      = CW'(XFER_CYCLES - 1);
  // Count value seen in the last ISSUE cycle; next cycle the counter shows
  // XFER_CYCLES-1-CMD_HOLD and the FSM is in WAIT.
  localparam logic [CW-1:0] CNT_ISSUE_END = CW'(XFER_CYCLES - CMD_HOLD);

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [2:0]    cmd_reg;
  logic [DW-1:0] wdata_reg;
  logic          id_reg;
  logic          rsp_id_reg;
  logic          rsp_err_reg;
  logic [DW-1:0] rsp_rdata_reg;

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic [1:0]    ready;
  logic          accept;
  logic          sel_id;
  logic [2:0]    sel_cmd;
  logic [DW-1:0] sel_wdata;
  logic          sel_valid_cmd;

  assign req = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  // Ready is also forced low while reset is asserted so every output reads 0.
  assign ready         = gnt & {2{(state_reg == IDLE) & rst}};
  assign accept        = |(req & ready);
  assign sel_id        = ready[1];
  assign sel_cmd       = sel_id ? bus.req1_cmd   : bus.req0_cmd;
  assign sel_wdata     = sel_id ? bus.req1_wdata : bus.req0_wdata;
  assign sel_valid_cmd = is_valid_cmd(sel_cmd);

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.rsp_valid  = (state_reg == RESP);
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_err    = rsp_err_reg;
  assign bus.rsp_rdata  = rsp_rdata_reg;
  assign bus.busy       = (state_reg != IDLE);

  assign i2c_command = (state_reg == ISSUE) ? {{(DW-3){1'b0}}, cmd_reg} : '0;
  assign i2c_dataIn  = (state_reg != IDLE) ? wdata_reg : '0;

  always_comb begin
    state_next = state_reg;
    count_next = (count_reg != '0) ? count_reg - CW'(1) : count_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (sel_valid_cmd) begin
            state_next = ISSUE;
            count_next = CNT_LOAD;
          end else begin
            state_next = RESP;
          end
        end
      end
      ISSUE:   if (count_reg == CNT_ISSUE_END) state_next = WAIT;
      WAIT:    if (count_reg == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      cmd_reg       <= CMD_IDLE;
      wdata_reg     <= '0;
      id_reg        <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (accept) begin
        cmd_reg   <= sel_cmd;
        wdata_reg <= sel_valid_cmd ? sel_wdata : '0;
        id_reg    <= sel_id;
      end
      // Response fields change only on entry to RESP and hold afterwards.
      if (state_next == RESP && state_reg != RESP) begin
        if (state_reg == IDLE) begin
          rsp_id_reg    <= sel_id;
          rsp_err_reg   <= 1'b1;
          rsp_rdata_reg <= '0;
        end else begin
          rsp_id_reg    <= id_reg;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= i2c_dataOut;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: single transfers, read capture, contention,
// invalid command, mid-transfer reset and request holding.
module tb_i2c_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i2c_command;
  logic [31:0] i2c_dataIn;
  logic [31:0] i2c_dataOut;

  int errors = 0;
  int checks = 0;

  i2c_arbiter_if #(.DW(32)) arb_if ();

  i2c_arbiter #(
    .CMD_HOLD    (4),
    .XFER_CYCLES (40),
    .DW          (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (arb_if),
    .i2c_command (i2c_command),
    .i2c_dataIn  (i2c_dataIn),
    .i2c_dataOut (i2c_dataOut)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arb_if.req0_valid = 1'b0;
    arb_if.req0_cmd   = 3'b000;
    arb_if.req0_wdata = '0;
    arb_if.req1_valid = 1'b0;
    arb_if.req1_cmd   = 3'b000;
    arb_if.req1_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();
  endtask

  int exp_order [6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    int cnt0, cnt1, accepts, resps, last_acc, cyc, saw_rsp;
    logic acc0, acc1;

    idle_inputs();
    i2c_dataOut = 32'h0;

    // Reset state, including ready forced low while in reset
    repeat (3) @(posedge clk);
    #1;
    arb_if.req0_valid = 1'b1;
    #1;
    check_val("rst_ready0", 32'(arb_if.req0_ready), 32'd0);
    check_val("rst_busy", 32'(arb_if.busy), 32'd0);
    check_val("rst_rsp_valid", 32'(arb_if.rsp_valid), 32'd0);
    check_val("rst_cmd", i2c_command, 32'd0);
    check_val("rst_dataIn", i2c_dataIn, 32'd0);
    check_val("rst_rdata", arb_if.rsp_rdata, 32'd0);
    arb_if.req0_valid = 1'b0;
    #1 rst = 1'b1;
    tick();

    // Port 0 WRITE
    arb_if.req0_valid = 1'b1;
    arb_if.req0_cmd   = 3'b001;
    arb_if.req0_wdata = 32'h0000_54AA;
    #1;
    check_val("t1_ready0", 32'(arb_if.req0_ready), 32'd1);
    check_val("t1_ready1", 32'(arb_if.req1_ready), 32'd0);
    $display("txn: port0 WRITE wdata=0x000054AA accepted");
    tick();
    arb_if.req0_valid = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      check_val($sformatf("t1_cmd@%0d", k), i2c_command, (k <= 4) ? 32'd1 : 32'd0);
      check_val($sformatf("t1_dataIn@%0d", k), i2c_dataIn, 32'h0000_54AA);
      check_val($sformatf("t1_rsp_valid@%0d", k), 32'(arb_if.rsp_valid), (k == 41) ? 32'd1 : 32'd0);
      check_val($sformatf("t1_busy@%0d", k), 32'(arb_if.busy), 32'd1);
      if (k < 41) tick();
    end
    check_val("t1_rsp_id", 32'(arb_if.rsp_id), 32'd0);
    check_val("t1_rsp_err", 32'(arb_if.rsp_err), 32'd0);
    tick();
    check_val("t1_idle_dataIn", i2c_dataIn, 32'd0);
    check_val("t1_idle_busy", 32'(arb_if.busy), 32'd0);
    check_val("t1_idle_rsp_valid", 32'(arb_if.rsp_valid), 32'd0);

    // Port 1 READ, dataOut valid from T+30
    arb_if.req1_valid = 1'b1;
    arb_if.req1_cmd   = 3'b010;
    i2c_dataOut = 32'h1111_1111;
    #1;
    check_val("t2_ready1", 32'(arb_if.req1_ready), 32'd1);
    $display("txn: port1 READ accepted");
    tick();
    arb_if.req1_valid = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      i2c_dataOut = (k >= 30 && k <= 40) ? 32'hDEAD_BEEF : 32'h1111_1111;
      if (k == 1) check_val("t2_cmd@1", i2c_command, 32'd2);
      if (k == 5) check_val("t2_cmd@5", i2c_command, 32'd0);
      if (k < 41) tick();
    end
    check_val("t2_rsp_valid", 32'(arb_if.rsp_valid), 32'd1);
    check_val("t2_rsp_rdata", arb_if.rsp_rdata, 32'hDEAD_BEEF);
    check_val("t2_rsp_id", 32'(arb_if.rsp_id), 32'd1);
    check_val("t2_rsp_err", 32'(arb_if.rsp_err), 32'd0);
    tick();
    check_val("t2_hold_rdata", arb_if.rsp_rdata, 32'hDEAD_BEEF);
    check_val("t2_hold_id", 32'(arb_if.rsp_id), 32'd1);
    check_val("t2_after_rsp_valid", 32'(arb_if.rsp_valid), 32'd0);
    i2c_dataOut = 32'h0;

    // Contention from reset: three READs per port
    do_reset();
    arb_if.req0_valid = 1'b1;
    arb_if.req0_cmd   = 3'b010;
    arb_if.req1_valid = 1'b1;
    arb_if.req1_cmd   = 3'b010;
    #1;
    cnt0 = 3; cnt1 = 3; accepts = 0; resps = 0; last_acc = 0; cyc = 0;
    while ((accepts < 6 || resps < 6) && cyc < 400) begin
      cyc++;
      if (arb_if.rsp_valid) begin
        if (resps < 6)
          check_val($sformatf("t3_rsp_id%0d", resps), 32'(arb_if.rsp_id), 32'(exp_order[resps]));
        $display("txn: contention response id=%0d cycle=%0d", arb_if.rsp_id, cyc);
        resps++;
      end
      acc0 = arb_if.req0_valid & arb_if.req0_ready;
      acc1 = arb_if.req1_valid & arb_if.req1_ready;
      if (acc0 | acc1) begin
        if (accepts < 6)
          check_val($sformatf("t3_grant%0d", accepts), 32'(acc1), 32'(exp_order[accepts]));
        if (accepts > 0)
          check_val($sformatf("t3_gap%0d", accepts), 32'(cyc - last_acc), 32'd42);
        $display("txn: contention accept port=%0d cycle=%0d", acc1, cyc);
        last_acc = cyc;
        accepts++;
        if (acc0) cnt0--;
        if (acc1) cnt1--;
      end
      tick();
      if (cnt0 == 0) arb_if.req0_valid = 1'b0;
      if (cnt1 == 0) arb_if.req1_valid = 1'b0;
    end
    check_val("t3_accepts", 32'(accepts), 32'd6);
    check_val("t3_resps", 32'(resps), 32'd6);
    idle_inputs();
    tick();

    // Invalid command
    arb_if.req0_valid = 1'b1;
    arb_if.req0_cmd   = 3'b111;
    arb_if.req0_wdata = 32'hFFFF_FFFF;
    #1;
    check_val("t4_ready0", 32'(arb_if.req0_ready), 32'd1);
    $display("txn: port0 invalid cmd=7 accepted");
    tick();
    arb_if.req0_valid = 1'b0;
    check_val("t4_rsp_valid", 32'(arb_if.rsp_valid), 32'd1);
    check_val("t4_rsp_err", 32'(arb_if.rsp_err), 32'd1);
    check_val("t4_rsp_rdata", arb_if.rsp_rdata, 32'd0);
    check_val("t4_rsp_id", 32'(arb_if.rsp_id), 32'd0);
    check_val("t4_cmd", i2c_command, 32'd0);
    check_val("t4_dataIn", i2c_dataIn, 32'd0);
    tick();
    check_val("t4_after_rsp_valid", 32'(arb_if.rsp_valid), 32'd0);
    check_val("t4_after_busy", 32'(arb_if.busy), 32'd0);
    check_val("t4_after_cmd", i2c_command, 32'd0);

    // Asynchronous reset at T+10 of a WRITE
    arb_if.req0_valid = 1'b1;
    arb_if.req0_cmd   = 3'b001;
    arb_if.req0_wdata = 32'h0000_A5A5;
    #1;
    $display("txn: port0 WRITE wdata=0x0000A5A5 accepted, reset follows");
    tick();
    arb_if.req0_valid = 1'b0;
    repeat (9) tick();
    check_val("t5_busy_pre", 32'(arb_if.busy), 32'd1);
    check_val("t5_dataIn_pre", i2c_dataIn, 32'h0000_A5A5);
    #3 rst = 1'b0;
    #1;
    check_val("t5_busy_async", 32'(arb_if.busy), 32'd0);
    check_val("t5_cmd_async", i2c_command, 32'd0);
    check_val("t5_dataIn_async", i2c_dataIn, 32'd0);
    check_val("t5_rsp_valid_async", 32'(arb_if.rsp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    saw_rsp = 0;
    for (int k = 0; k < 60; k++) begin
      if (arb_if.rsp_valid) saw_rsp++;
      tick();
    end
    check_val("t5_no_rsp", 32'(saw_rsp), 32'd0);
    arb_if.req1_valid = 1'b1;
    arb_if.req1_cmd   = 3'b010;
    #1;
    check_val("t5_ready1_after", 32'(arb_if.req1_ready), 32'd1);
    $display("txn: port1 READ accepted after reset");
    tick();
    arb_if.req1_valid = 1'b0;
    repeat (40) tick();
    check_val("t5_rsp_valid", 32'(arb_if.rsp_valid), 32'd1);
    check_val("t5_rsp_id", 32'(arb_if.rsp_id), 32'd1);
    tick();

    // Port 1 held off during port 0 transfer, payload changed while waiting
    arb_if.req0_valid = 1'b1;
    arb_if.req0_cmd   = 3'b001;
    arb_if.req0_wdata = 32'h0000_0F0F;
    arb_if.req1_valid = 1'b1;
    arb_if.req1_cmd   = 3'b001;
    arb_if.req1_wdata = 32'h0000_1234;
    #1;
    check_val("t6_ready0", 32'(arb_if.req0_ready), 32'd1);
    check_val("t6_ready1", 32'(arb_if.req1_ready), 32'd0);
    $display("txn: port0 WRITE wdata=0x00000F0F accepted, port1 waiting");
    tick();
    arb_if.req0_valid = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      check_val($sformatf("t6_ready1@%0d", k), 32'(arb_if.req1_ready), 32'd0);
      if (k == 20) begin
        arb_if.req1_cmd   = 3'b010;
        arb_if.req1_wdata = 32'h0000_CAFE;
      end
      tick();
    end
    check_val("t6_ready1_idle", 32'(arb_if.req1_ready), 32'd1);
    $display("txn: port1 READ wdata=0x0000CAFE accepted");
    tick();
    arb_if.req1_valid = 1'b0;
    check_val("t6_cmd", i2c_command, 32'd2);
    check_val("t6_dataIn", i2c_dataIn, 32'h0000_CAFE);
    repeat (40) tick();
    check_val("t6_rsp_valid", 32'(arb_if.rsp_valid), 32'd1);
    check_val("t6_rsp_id", 32'(arb_if.rsp_id), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
